// File: rtl/vendo_multi.sv
// Multi-item vending controller: per-item prices, three coin denominations,
// saturating credit with coin rejection, cancel/refund and serial change return.

module vendo_multi_lane #(
  parameter int                 PRICE_W = 6,
  parameter logic [PRICE_W-1:0] PRICE   = '0
) (
  input  logic [PRICE_W-1:0] credit,
  input  logic               sel_bit,
  output logic               afford,
  output logic [PRICE_W-1:0] price_m
);
  assign afford  = sel_bit && (credit >= PRICE);
  assign price_m = sel_bit ? PRICE : '0;
endmodule

module vendo_multi #(
  parameter int                           NUM_ITEMS  = 4,
  parameter int                           PRICE_W    = 6,
  parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICES     = {6'd15, 6'd12, 6'd8, 6'd6},
  parameter int                           MAX_CREDIT = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_ITEMS-1:0] sel,
  input  logic                 p_1,
  input  logic                 p_5,
  input  logic                 p_10,
  input  logic                 cancel,
  output logic [NUM_ITEMS-1:0] disp,
  output logic                 change,
  output logic                 coin_reject,
  output logic                 sel_err,
  output logic [PRICE_W-1:0]   credit,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

  state_t               state_q, state_d;
  logic [PRICE_W-1:0]   credit_q, credit_d;
  logic [NUM_ITEMS-1:0] item_q, item_d;
  logic [NUM_ITEMS-1:0] disp_q, disp_d;
  logic                 change_q, change_d;
  logic                 reject_q, reject_d;
  logic                 sel_err_q, sel_err_d;
  logic                 busy_q, busy_d;

  // Selection is held one-hot so each lane masks its own price.
  logic [NUM_ITEMS-1:0]              afford;
  logic [NUM_ITEMS-1:0][PRICE_W-1:0] price_m;
  logic [PRICE_W-1:0]                price_sel;

  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_lane
    vendo_multi_lane #(
      .PRICE_W (PRICE_W),
      .PRICE   (PRICES[i*PRICE_W +: PRICE_W])
    ) u_lane (
      .credit  (credit_q),
      .sel_bit (item_q[i]),
      .afford  (afford[i]),
      .price_m (price_m[i])
    );
  end

  always_comb begin
    price_sel = '0;
    for (int i = 0; i < NUM_ITEMS; i++) price_sel = price_sel | price_m[i];
  end

  logic               coin_any, coin_one, sel_one, sel_any;
  logic [PRICE_W:0]   coin_val, coin_sum;
  logic [PRICE_W-1:0] remainder;

  assign coin_any  = p_1 | p_5 | p_10;
  assign coin_one  = coin_any && ({1'b0, p_1} + {1'b0, p_5} + {1'b0, p_10} == 2'd1);
  assign coin_val  = p_10 ? (PRICE_W+1)'(10) : p_5 ? (PRICE_W+1)'(5) : (PRICE_W+1)'(1);
  assign coin_sum  = {1'b0, credit_q} + coin_val;
  assign sel_any   = |sel;
  assign sel_one   = sel_any && ((sel & (sel - 1'b1)) == '0);
  assign remainder = credit_q - price_sel;

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    item_d    = item_q;
    reject_d  = 1'b0;
    sel_err_d = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (cancel) begin
          item_d   = '0;
          reject_d = coin_any;
          state_d  = (credit_q != '0) ? CHANGE : IDLE;
        end else begin
          if (coin_any) begin
            if (coin_one && coin_sum <= (PRICE_W+1)'(MAX_CREDIT)) credit_d = coin_sum[PRICE_W-1:0];
            else reject_d = 1'b1;
          end
          // An affordable latched item wins over a sel arriving on the same edge.
          if (state_q == COLLECT && |afford) begin
            state_d = DISPENSE;
          end else if (sel_one) begin
            item_d  = sel;
            state_d = COLLECT;
          end else if (sel_any) begin
            sel_err_d = 1'b1;
          end
        end
      end
      DISPENSE: begin
        reject_d = coin_any;
        credit_d = remainder;
        item_d   = '0;
        state_d  = (remainder != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_d = coin_any;
        if (credit_q != '0) credit_d = credit_q - 1'b1;
        if (credit_q <= PRICE_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_comb begin
    disp_d   = (state_d == DISPENSE) ? item_d : '0;
    change_d = (state_d == CHANGE);
    busy_d   = (state_d == DISPENSE) || (state_d == CHANGE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      credit_q  <= '0;
      item_q    <= '0;
      disp_q    <= '0;
      change_q  <= 1'b0;
      reject_q  <= 1'b0;
      sel_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      item_q    <= item_d;
      disp_q    <= disp_d;
      change_q  <= change_d;
      reject_q  <= reject_d;
      sel_err_q <= sel_err_d;
      busy_q    <= busy_d;
    end
  end

  assign disp        = disp_q;
  assign change      = change_q;
  assign coin_reject = reject_q;
  assign sel_err     = sel_err_q;
  assign credit      = credit_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vendo_multi.sv
// Directed plus randomized bench for vendo_multi against a transaction-level
// model that tracks credit, the chosen item, a pending dispense and refunding.

module tb_vendo_multi;
  localparam int N = 4, W = 6, MAXC = 40;
  localparam logic [N*W-1:0] PR = {6'd15, 6'd12, 6'd8, 6'd6};

  logic         clk = 1'b0;
  logic         rst, p_1, p_5, p_10, cancel;
  logic [N-1:0] sel;
  logic [N-1:0] disp;
  logic         change, coin_reject, sel_err, busy;
  logic [W-1:0] credit;

  vendo_multi #(.NUM_ITEMS(N), .PRICE_W(W), .PRICES(PR), .MAX_CREDIT(MAXC)) dut (
    .clk(clk), .rst(rst), .sel(sel), .p_1(p_1), .p_5(p_5), .p_10(p_10), .cancel(cancel),
    .disp(disp), .change(change), .coin_reject(coin_reject), .sel_err(sel_err),
    .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int m_credit = 0, m_item = -1, m_disp = -1;
  bit m_refund = 0, m_rej = 0, m_err = 0;
  int n_disp = 0, n_change = 0, n_busy = 0;

  function automatic int price(int i);
    logic [N*W-1:0] v;
    v = PR;
    return int'(v[i*W +: W]);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Next-cycle expectation from the rules, given the inputs about to be sampled.
  task automatic model_step();
    int nc, val, old;
    nc = int'(p_1) + int'(p_5) + int'(p_10);
    val = p_10 ? 10 : p_5 ? 5 : 1;
    m_rej = 0; m_err = 0;
    if (rst) begin
      m_credit = 0; m_item = -1; m_disp = -1; m_refund = 0;
    end else if (m_disp >= 0) begin
      m_credit = m_credit - price(m_disp);
      m_refund = (m_credit > 0);
      m_disp = -1; m_item = -1;
      m_rej = (nc > 0);
    end else if (m_refund) begin
      m_credit--;
      if (m_credit == 0) m_refund = 0;
      m_rej = (nc > 0);
    end else if (cancel) begin
      m_rej = (nc > 0);
      m_item = -1;
      m_refund = (m_credit > 0);
    end else begin
      old = m_credit;
      if (nc == 1 && m_credit + val <= MAXC) m_credit += val;
      else if (nc > 0) m_rej = 1;
      if (m_item >= 0 && old >= price(m_item)) m_disp = m_item;
      else if ($countones(sel) == 1) begin
        for (int i = 0; i < N; i++) if (sel[i]) m_item = i;
      end else if (sel != 0) m_err = 1;
    end
  endtask

  task automatic step(logic r, logic [N-1:0] s, logic c1, logic c5, logic c10, logic cn);
    rst = r; sel = s; p_1 = c1; p_5 = c5; p_10 = c10; cancel = cn;
    @(posedge clk);
    model_step();
    #1;
    chk("disp", 32'(disp), (m_disp >= 0) ? 32'(1) << m_disp : 32'd0);
    chk("change", 32'(change), 32'(m_refund));
    chk("coin_reject", 32'(coin_reject), 32'(m_rej));
    chk("sel_err", 32'(sel_err), 32'(m_err));
    chk("credit", 32'(credit), 32'(m_credit));
    chk("busy", 32'(busy), 32'(m_disp >= 0 || m_refund));
    n_disp += int'(disp != 0); n_change += int'(change); n_busy += int'(busy);
    rst = 0; sel = '0; p_1 = 0; p_5 = 0; p_10 = 0; cancel = 0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0);
  endtask

  task automatic clr();
    n_disp = 0; n_change = 0; n_busy = 0;
  endtask

  initial begin
    logic [N-1:0] s;
    rst = 1; sel = '0; p_1 = 0; p_5 = 0; p_10 = 0; cancel = 0;
    step(1, '0, 0, 0, 0, 0);
    chk("reset_credit", 32'(credit), 0);
    chk("reset_busy", 32'(busy), 0);

    // Exact-price purchase
    clr();
    step(0, 4'b0001, 0, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0);
    chk("t1_credit1", 32'(credit), 1);
    step(0, '0, 0, 1, 0, 0);
    chk("t1_credit6", 32'(credit), 6);
    idle(4);
    chk("t1_disp_cnt", 32'(n_disp), 1);
    chk("t1_change_cnt", 32'(n_change), 0);
    chk("t1_busy_cnt", 32'(n_busy), 1);
    chk("t1_credit0", 32'(credit), 0);

    // Purchase with change
    clr();
    step(0, 4'b0010, 0, 0, 0, 0);
    step(0, '0, 0, 1, 0, 0);
    step(0, '0, 0, 1, 0, 0);
    chk("t2_credit10", 32'(credit), 10);
    idle(6);
    chk("t2_disp_cnt", 32'(n_disp), 1);
    chk("t2_change_cnt", 32'(n_change), 2);

    // Saturation, overflow reject and full refund
    clr();
    for (int i = 0; i < 4; i++) step(0, '0, 0, 0, 1, 0);
    chk("t3_credit40", 32'(credit), 40);
    step(0, '0, 0, 0, 1, 0);
    chk("t3_reject", 32'(coin_reject), 1);
    chk("t3_credit_hold", 32'(credit), 40);
    step(0, '0, 0, 0, 0, 1);
    idle(45);
    chk("t3_change_cnt", 32'(n_change), 40);
    chk("t3_disp_cnt", 32'(n_disp), 0);

    // Multi-hot sel, double coin, selection replacement
    clr();
    step(0, 4'b0011, 0, 0, 0, 0);
    chk("t4_sel_err", 32'(sel_err), 1);
    step(0, '0, 1, 1, 0, 0);
    chk("t4_reject", 32'(coin_reject), 1);
    chk("t4_credit0", 32'(credit), 0);
    step(0, 4'b1000, 0, 0, 1, 0);
    step(0, '0, 0, 0, 0, 0);
    step(0, 4'b0001, 0, 0, 0, 0);
    idle(8);
    chk("t4_disp_cnt", 32'(n_disp), 1);
    chk("t4_change_cnt", 32'(n_change), 4);

    // Coin during CHANGE, then reset mid-CHANGE
    clr();
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1, 0);
    step(0, 4'b0001, 0, 0, 0, 0);
    idle(4);
    step(0, '0, 0, 1, 0, 0);
    chk("t5_reject", 32'(coin_reject), 1);
    idle(2);
    step(1, '0, 0, 0, 0, 0);
    chk("t5_rst_change", 32'(change), 0);
    chk("t5_rst_credit", 32'(credit), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    idle(2);

    // Cancel with zero credit
    clr();
    step(0, 4'b0001, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 1);
    idle(2);
    step(0, '0, 0, 0, 1, 0);
    step(0, '0, 0, 0, 1, 0);
    idle(3);
    chk("t6_credit20", 32'(credit), 20);
    chk("t6_disp_cnt", 32'(n_disp), 0);
    chk("t6_change_cnt", 32'(n_change), 0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 7))
        0:       s = N'(1) << $urandom_range(0, N-1);
        1:       s = N'($urandom);
        default: s = '0;
      endcase
      step($urandom_range(0, 199) == 0, s,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
